// File: rtl/matvec_pkg.sv
// Shared types and sizes for the matvec3 host-side stream driver.
package matvec_pkg;

    localparam int N_DIM  = 3;
    localparam int IN_W   = 14;
    localparam int OUT_W  = 2 * IN_W;
    localparam int N_OPS  = N_DIM * N_DIM + N_DIM;
    localparam int OPS_AW = $clog2(N_OPS);
    localparam int RES_AW = $clog2(N_DIM);

    typedef logic signed [IN_W-1:0]  in_word_t;
    typedef logic signed [OUT_W-1:0] out_word_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_W,
        SEND_X,
        RECV,
        DONE
    } drv_state_t;

endpackage

// File: rtl/matvec_stream_driver_if.sv
// Operand (m_*) and result (s_*) valid/ready streams between the driver and matvec3.
interface matvec_stream_driver_if;
    import matvec_pkg::*;

    logic      m_valid;
    logic      m_ready;
    in_word_t  m_data;
    logic      s_valid;
    logic      s_ready;
    out_word_t s_data;

    // Driver side: sources operands, sinks results.
    modport master (
        output m_valid, m_data, s_ready,
        input  m_ready, s_valid, s_data
    );

    // Compute-unit side.
    modport slave (
        input  m_valid, m_data, s_ready,
        output m_ready, s_valid, s_data
    );

endinterface

// File: rtl/matvec_stream_driver_regfile.sv
// Small register array: one synchronous write port, one combinational read port,
// synchronous clear. Out-of-range writes are dropped, out-of-range reads give 0.
module drv_regfile #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];

    // Storage: clear everything on reset, otherwise take in-range writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i && ({1'b0, waddr_i} < DEPTH_L)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read, guarded against addresses past the end.
    always_comb begin
        rdata_o = '0;
        if ({1'b0, raddr_i} < DEPTH_L) rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/matvec_stream_driver.sv
// Host-side traffic source/sink for matvec3: streams W (row-major) then X out,
// collects N results back, pulses done.
module matvec_stream_driver
    import matvec_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [OPS_AW-1:0]     load_addr,
    input  in_word_t              load_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    matvec_stream_driver_if.master mst,
    input  logic [RES_AW-1:0]     rd_addr,
    output out_word_t             rd_data
);

    localparam logic [OPS_AW-1:0] X_BASE = OPS_AW'(N_DIM * N_DIM);
    localparam logic [OPS_AW-1:0] W_LAST = OPS_AW'(N_DIM * N_DIM - 1);
    localparam logic [OPS_AW-1:0] V_LAST = OPS_AW'(N_DIM - 1);

    drv_state_t          state_q;
    logic [OPS_AW-1:0]   cnt_q;
    logic                m_valid_q;
    in_word_t            m_data_q;
    logic                s_ready_q;
    logic                busy_q;
    logic                done_q;

    logic                op_we;
    logic [OPS_AW-1:0]   op_raddr;
    in_word_t            op_rdata;
    in_word_t            op_word;
    logic                xfer;
    logic                cap;
    out_word_t           res_rdata;

    // Operands are only writable in IDLE, which freezes them for a transaction.
    assign op_we = load_en && (state_q == IDLE);
    assign xfer  = m_valid_q && mst.m_ready;
    assign cap   = (state_q == RECV) && mst.s_valid && s_ready_q;

    // Address of the word to present after the current transfer (W[0] from IDLE);
    // SEND_W at its last count naturally points at X[0].
    always_comb begin
        op_raddr = '0;
        case (state_q)
            SEND_W:  op_raddr = cnt_q + OPS_AW'(1);
            SEND_X:  op_raddr = X_BASE + cnt_q + OPS_AW'(1);
            default: op_raddr = '0;
        endcase
    end

    // Forward a same-cycle load so start+load transmits the fresh word.
    always_comb begin
        op_word = op_rdata;
        if (op_we && (load_addr == op_raddr)) op_word = load_data;
    end

    drv_regfile #(.DEPTH(N_OPS), .W(IN_W), .AW(OPS_AW)) u_ops (
        .clk     (clk),
        .reset   (reset),
        .we_i    (op_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (op_raddr),
        .rdata_o (op_rdata)
    );

    drv_regfile #(.DEPTH(N_DIM), .W(OUT_W), .AW(RES_AW)) u_res (
        .clk     (clk),
        .reset   (reset),
        .we_i    (cap),
        .waddr_i (cnt_q[RES_AW-1:0]),
        .wdata_i (s_data_w()),
        .raddr_i (rd_addr),
        .rdata_o (res_rdata)
    );

    function automatic out_word_t s_data_w();
        return mst.s_data;
    endfunction

    // Transaction FSM with registered handshake outputs and inline word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= SEND_W;
                        cnt_q     <= '0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= op_word;
                        busy_q    <= 1'b1;
                    end
                end
                SEND_W: begin
                    if (xfer) begin
                        m_data_q <= op_word;
                        if (cnt_q == W_LAST) begin
                            state_q <= SEND_X;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + OPS_AW'(1);
                        end
                    end
                end
                SEND_X: begin
                    if (xfer) begin
                        if (cnt_q == V_LAST) begin
                            state_q   <= RECV;
                            cnt_q     <= '0;
                            m_valid_q <= 1'b0;
                            s_ready_q <= 1'b1;
                        end else begin
                            cnt_q    <= cnt_q + OPS_AW'(1);
                            m_data_q <= op_word;
                        end
                    end
                end
                RECV: begin
                    if (cap) begin
                        if (cnt_q == V_LAST) begin
                            state_q   <= DONE;
                            cnt_q     <= '0;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + OPS_AW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mst.m_valid = m_valid_q;
    assign mst.m_data  = m_data_q;
    assign mst.s_ready = s_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_data     = res_rdata;

endmodule

// File: tb/tb_matvec_stream_driver.sv
// Scoreboard bench for the matvec3 stream driver: stimulus pushes expected
// operand words, a negedge monitor pops/compares on every transfer.
module tb_matvec_stream_driver;
    import matvec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                load_en;
    logic [OPS_AW-1:0]   load_addr;
    in_word_t            load_data;
    logic                start;
    logic                busy;
    logic                done;
    logic [RES_AW-1:0]   rd_addr;
    out_word_t           rd_data;

    matvec_stream_driver_if bus ();

    matvec_stream_driver dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mst       (bus.master),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    int xfer_cnt = 0;
    int done_cnt = 0;
    int last_cap = -10;
    logic hold_v = 1'b0;
    int hold_d   = 0;
    int res_model[3];

    int W1[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 0, -1};
    int W5[12]   = '{5, 2, 3, 4, 5, 6, 7, 8, 9, 1, 0, -1};
    int ZERO[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int ALL1[5]  = '{1, 1, 1, 1, 1};
    int GAPS[5]  = '{1, 0, 0, 1, 1};

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: stability under back-pressure, in-order operand words,
    // capture bookkeeping and done-pulse timing.
    always @(negedge clk) begin
        int d;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            d = int'(bus.m_data);
            if (hold_v) begin
                check("hold_valid", int'(bus.m_valid), 1);
                check("hold_data", d, hold_d);
            end
            hold_v = bus.m_valid && !bus.m_ready;
            hold_d = d;
            if (bus.m_valid && bus.m_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got word %0d expected no transfer", d);
                end else begin
                    check("m_data", d, exp_q.pop_front());
                end
            end
            if (bus.s_valid && bus.s_ready) last_cap = cyc;
            if (done) begin
                done_cnt++;
                check("done_timing", cyc, last_cap + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(int a, int d);
        load_en   = 1'b1;
        load_addr = OPS_AW'(a);
        load_data = in_word_t'(d);
        step();
        load_en   = 1'b0;
    endtask

    task automatic load_set(int w[12]);
        for (int i = 0; i < 12; i++) load_word(i, w[i]);
    endtask

    task automatic push_exp(int w[12]);
        for (int i = 0; i < 12; i++) exp_q.push_back(w[i]);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_xfers(int target, bit toggle);
        for (int i = 0; i < 200 && xfer_cnt < target; i++) begin
            bus.m_ready = toggle ? ((i % 2) == 0) : 1'b1;
            step();
        end
        bus.m_ready = 1'b1;
        check("xfer_count", xfer_cnt, target);
    endtask

    task automatic recv(int v[3], int pat[5]);
        int k;
        k = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            bus.s_valid = (pat[i % 5] != 0);
            bus.s_data  = out_word_t'(v[k]);
            if (bus.s_valid && bus.s_ready) begin
                res_model[k] = v[k];
                k++;
            end
            step();
        end
        bus.s_valid = 1'b0;
        check("recv_count", k, 3);
        check("done_after_last_cap", int'(done), 1);
    endtask

    task automatic check_results();
        for (int a = 0; a < 3; a++) begin
            rd_addr = RES_AW'(a);
            #1;
            check("rd_data", int'(rd_data), res_model[a]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        int R1[3] = '{100, -200, 300};
        int R2[3] = '{-2, -2, -2};
        int R3[3] = '{5, 6, 7};
        int R4[3] = '{134217727, -134217728, 0};
        int R5[3] = '{1, 2, 3};

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        rd_addr = '0; bus.m_ready = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        res_model = '{0, 0, 0};
        step(); step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_m_data", int'(bus.m_data), 0);
        check("rst_s_ready", int'(bus.s_ready), 0);
        reset = 1'b0;
        check_results();

        // Plain transaction with m_ready held high: cycle-exact latency.
        load_set(W1);
        push_exp(W1);
        bus.m_ready = 1'b1;
        base = xfer_cnt;
        kick();
        check("c1_m_valid", int'(bus.m_valid), 1);
        check("c1_busy", int'(busy), 1);
        check("c1_m_data", int'(bus.m_data), 1);
        repeat (12) step();
        check("c13_xfers", xfer_cnt - base, 12);
        check("c13_m_valid", int'(bus.m_valid), 0);
        check("c13_s_ready", int'(bus.s_ready), 1);
        recv(R1, ALL1);
        check("c16_busy", int'(busy), 0);
        check_results();
        step();

        // Back-pressure: m_ready toggling, then gapped result stream.
        push_exp(W1);
        base = xfer_cnt;
        kick();
        wait_xfers(base + 12, 1'b1);
        step(); step();
        check("no_extra_xfer", xfer_cnt - base, 12);
        check("recv_s_ready", int'(bus.s_ready), 1);
        dbase = done_cnt;
        recv(R2, GAPS);
        step(); step();
        check("done_once", done_cnt - dbase, 1);
        rd_addr = 2'd2;
        #1;
        check("rd_addr2", int'(rd_data), -2);
        check_results();

        // start + load while busy are ignored.
        push_exp(W1);
        base = xfer_cnt;
        kick();
        step();
        start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 14'sd99;
        step();
        start = 1'b0; load_en = 1'b0;
        wait_xfers(base + 12, 1'b0);
        recv(R3, ALL1);
        check_results();
        step();

        // s_valid outside RECV is never acknowledged; W[0] still 1.
        bus.s_valid = 1'b1;
        bus.s_data  = 28'sd777;
        step();
        check("s_ready_idle", int'(bus.s_ready), 0);
        push_exp(W1);
        base = xfer_cnt;
        kick();
        check("s_ready_sendw", int'(bus.s_ready), 0);
        check("w0_kept", int'(bus.m_data), 1);
        step();
        check("s_ready_sendw2", int'(bus.s_ready), 0);
        bus.s_valid = 1'b0;
        check_results();
        wait_xfers(base + 12, 1'b0);
        recv(R4, ALL1);
        check_results();
        step();

        // Reset after the 5th transfer abandons the transaction.
        push_exp(W1);
        base = xfer_cnt;
        kick();
        wait_xfers(base + 5, 1'b0);
        reset = 1'b1;
        bus.m_ready = 1'b0;
        exp_q.delete();
        step();
        reset = 1'b0;
        check("mid_rst_m_valid", int'(bus.m_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_m_data", int'(bus.m_data), 0);
        check("mid_rst_s_ready", int'(bus.s_ready), 0);
        res_model = '{0, 0, 0};
        check_results();

        // Cleared operand buffer streams zeros.
        bus.m_ready = 1'b1;
        push_exp(ZERO);
        base = xfer_cnt;
        kick();
        wait_xfers(base + 12, 1'b0);
        recv(R5, ALL1);
        check_results();
        step();

        // Reload; W[0] written in the same cycle as start is transmitted.
        for (int i = 1; i < 12; i++) load_word(i, W1[i]);
        push_exp(W5);
        base = xfer_cnt;
        load_en = 1'b1; load_addr = '0; load_data = 14'sd5; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        check("fresh_w0", int'(bus.m_data), 5);
        wait_xfers(base + 12, 1'b0);
        recv(R1, ALL1);
        check_results();
        step(); step();
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
